spi_xfer_ctrl: RTL and testbench

//  Sequences one SPI mode-0 (CPOL=0, CPHA=0) master transfer per request.

---
 rtl/spi_xfer_ctrl_if.sv | 25 ++
 rtl/spi_xfer_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_spi_xfer_ctrl.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/spi_xfer_ctrl_if.sv
// rtl/spi_xfer_ctrl_if.sv - request/response bundle between command front end and SPI transfer controller
interface spi_xfer_ctrl_if #(
    parameter int SPI_MAXLEN = 16,
    parameter int LEN_W      = $clog2(SPI_MAXLEN) + 1
);
    logic                  req_valid;
    logic                  req_ready;
    logic [LEN_W-1:0]      req_len;
    logic [SPI_MAXLEN-1:0] req_data;
    logic                  rsp_valid;
    logic [SPI_MAXLEN-1:0] rsp_data;
    logic                  rsp_err;

    // Front end: issues requests, consumes responses
    modport master (
        output req_valid, req_len, req_data,
        input  req_ready, rsp_valid, rsp_data, rsp_err
    );

    // Transfer controller: accepts requests, produces responses
    modport slave (
        input  req_valid, req_len, req_data,
        output req_ready, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/spi_xfer_ctrl.sv
// rtl/spi_xfer_ctrl.sv - SPI mode-0 master sequencing one transfer per request
module spi_xfer_ctrl #(
    parameter int SPI_MAXLEN = 16,
    parameter int DIV_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DIV_W-1:0] clk_div_i,
    spi_xfer_ctrl_if.slave   req_if,
    output logic             busy_o,
    output logic             spi_sclk_o,
    output logic             spi_cs_n_o,
    output logic             spi_mosi_o,
    input  logic             spi_miso_i
);
    localparam int LEN_W = $clog2(SPI_MAXLEN) + 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_HIGH,
        ST_LOW,
        ST_HOLD,
        ST_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [DIV_W-1:0]      h_q, h_d;
    logic [DIV_W-1:0]      hcnt_q, hcnt_d;
    logic [LEN_W-1:0]      bits_q, bits_d;
    logic [SPI_MAXLEN-1:0] tx_q, tx_d;
    logic [SPI_MAXLEN-1:0] rx_q, rx_d;
    logic [SPI_MAXLEN-1:0] rsp_data_q, rsp_data_d;
    logic                  mosi_q, mosi_d;
    logic                  err_q, err_d;
    logic                  hold_half_q, hold_half_d;

    logic [DIV_W-1:0]      h_eff;
    logic                  len_ok;
    logic [LEN_W-1:0]      tx_shamt;
    logic [SPI_MAXLEN-1:0] tx_aligned;
    logic                  cs_active;

    // Request decode: effective half period, legality, and MSB-first alignment of TX data
    always_comb begin
        h_eff      = (clk_div_i == '0) ? DIV_W'(1) : clk_div_i;
        len_ok     = (req_if.req_len != '0) && (req_if.req_len <= LEN_W'(SPI_MAXLEN));
        tx_shamt   = LEN_W'(SPI_MAXLEN) - req_if.req_len;
        tx_aligned = req_if.req_data << tx_shamt;
    end

    // Next-state and datapath updates; every register holds unless its phase says otherwise
    always_comb begin
        state_d     = state_q;
        h_d         = h_q;
        hcnt_d      = hcnt_q;
        bits_d      = bits_q;
        tx_d        = tx_q;
        rx_d        = rx_q;
        rsp_data_d  = rsp_data_q;
        mosi_d      = mosi_q;
        err_d       = err_q;
        hold_half_d = hold_half_q;

        case (state_q)
            ST_IDLE: begin
                if (req_if.req_valid) begin
                    h_d  = h_eff;
                    rx_d = '0;
                    if (len_ok) begin
                        state_d = ST_SETUP;
                        hcnt_d  = h_eff - DIV_W'(1);
                        bits_d  = req_if.req_len;
                        tx_d    = tx_aligned;
                        mosi_d  = tx_aligned[SPI_MAXLEN-1];
                        err_d   = 1'b0;
                    end else begin
                        // Illegal length: answer next cycle without touching the bus
                        state_d    = ST_DONE;
                        err_d      = 1'b1;
                        rsp_data_d = '0;
                    end
                end
            end

            ST_SETUP, ST_LOW: begin
                if (hcnt_q == '0) begin
                    // Rising SCLK edge: sample MISO as the bus enters HIGH
                    state_d = ST_HIGH;
                    hcnt_d  = h_q - DIV_W'(1);
                    rx_d    = {rx_q[SPI_MAXLEN-2:0], spi_miso_i};
                end else begin
                    hcnt_d = hcnt_q - DIV_W'(1);
                end
            end

            ST_HIGH: begin
                if (hcnt_q == '0) begin
                    bits_d = bits_q - LEN_W'(1);
                    hcnt_d = h_q - DIV_W'(1);
                    if (bits_q == LEN_W'(1)) begin
                        state_d     = ST_HOLD;
                        hold_half_d = 1'b0;
                    end else begin
                        // Falling SCLK edge: present the next bit
                        state_d = ST_LOW;
                        tx_d    = tx_q << 1;
                        mosi_d  = tx_q[SPI_MAXLEN-2];
                    end
                end else begin
                    hcnt_d = hcnt_q - DIV_W'(1);
                end
            end

            ST_HOLD: begin
                // Two half periods: the final SCLK-low time plus chip-select hold
                if (hcnt_q == '0) begin
                    if (!hold_half_q) begin
                        hold_half_d = 1'b1;
                        hcnt_d      = h_q - DIV_W'(1);
                    end else begin
                        state_d    = ST_DONE;
                        rsp_data_d = rx_q;
                    end
                end else begin
                    hcnt_d = hcnt_q - DIV_W'(1);
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any transfer at once
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            h_q         <= DIV_W'(1);
            hcnt_q      <= '0;
            bits_q      <= '0;
            tx_q        <= '0;
            rx_q        <= '0;
            rsp_data_q  <= '0;
            mosi_q      <= 1'b0;
            err_q       <= 1'b0;
            hold_half_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            h_q         <= h_d;
            hcnt_q      <= hcnt_d;
            bits_q      <= bits_d;
            tx_q        <= tx_d;
            rx_q        <= rx_d;
            rsp_data_q  <= rsp_data_d;
            mosi_q      <= mosi_d;
            err_q       <= err_d;
            hold_half_q <= hold_half_d;
        end
    end

    // Pin and handshake outputs decoded from the registered state
    always_comb begin
        cs_active        = (state_q == ST_SETUP) || (state_q == ST_HIGH) ||
                           (state_q == ST_LOW)   || (state_q == ST_HOLD);
        spi_cs_n_o       = !cs_active;
        spi_sclk_o       = (state_q == ST_HIGH);
        spi_mosi_o       = cs_active && mosi_q;
        busy_o           = (state_q != ST_IDLE);
        req_if.req_ready = (state_q == ST_IDLE) && rst;
        req_if.rsp_valid = (state_q == ST_DONE);
        req_if.rsp_err   = (state_q == ST_DONE) && err_q;
        req_if.rsp_data  = rsp_data_q;
    end
endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// tb/tb_spi_xfer_ctrl.sv - directed self-checking bench for spi_xfer_ctrl
module tb_spi_xfer_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] clk_div;
    logic        busy, sclk, cs_n, mosi, miso;
    int          miso_mode = 0;

    spi_xfer_ctrl_if #(.SPI_MAXLEN(16)) bus ();

    spi_xfer_ctrl #(.SPI_MAXLEN(16), .DIV_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .clk_div_i  (clk_div),
        .req_if     (bus),
        .busy_o     (busy),
        .spi_sclk_o (sclk),
        .spi_cs_n_o (cs_n),
        .spi_mosi_o (mosi),
        .spi_miso_i (miso)
    );

    assign miso = (miso_mode == 2) ? mosi : (miso_mode == 1);

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          cs_low_n = 0, rises_n = 0, rsp_n = 0, rsp_at = 0, hi_run = 0, last_gap = 0;
    logic [15:0] rsp_d = '0, mosi_seq = '0;
    logic        rsp_e = 1'b0, sclk_prev = 1'b0;

    always @(negedge clk) begin
        if (!cs_n) cs_low_n <= cs_low_n + 1;
        if (sclk && !sclk_prev) begin
            rises_n  <= rises_n + 1;
            mosi_seq <= {mosi_seq[14:0], mosi};
        end
        sclk_prev <= sclk;
        if (bus.rsp_valid) begin
            rsp_n  <= rsp_n + 1;
            rsp_at <= cyc;
            rsp_d  <= bus.rsp_data;
            rsp_e  <= bus.rsp_err;
        end
        if (cs_n) hi_run <= hi_run + 1;
        else begin
            if (hi_run != 0) last_gap <= hi_run;
            hi_run <= 0;
        end
    end

    int total = 0, bad = 0;
    int t0, t1, b_cs, b_rise, b_rsp;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start(input int len, input logic [15:0] data, input logic [15:0] div);
        @(negedge clk);
        bus.req_len   = len[4:0];
        bus.req_data  = data;
        clk_div       = div;
        bus.req_valid = 1'b1;
        t0     = cyc;
        b_cs   = cs_low_n;
        b_rise = rises_n;
        b_rsp  = rsp_n;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int limit);
        int n = 0;
        while (rsp_n == b_rsp && n < limit) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("rsp_seen", 32'(rsp_n != b_rsp), 32'd1);
    endtask

    initial begin
        rst           = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_len   = '0;
        bus.req_data  = '0;
        clk_div       = 16'd2;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cs_n", 32'(cs_n), 32'd1);
        chk("rst_sclk", 32'(sclk), 32'd0);
        chk("rst_mosi", 32'(mosi), 32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
        chk("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rel_ready", 32'(bus.req_ready), 32'd1);

        // 1: H=2, len 8, loopback
        miso_mode = 2;
        start(8, 16'h00A5, 16'd2);
        chk("t1_busy", 32'(busy), 32'd1);
        chk("t1_ready", 32'(bus.req_ready), 32'd0);
        wait_rsp(200);
        chk("t1_data", 32'(rsp_d), 32'h00A5);
        chk("t1_err", 32'(rsp_e), 32'd0);
        chk("t1_rises", 32'(rises_n - b_rise), 32'd8);
        chk("t1_cs_low", 32'(cs_low_n - b_cs), 32'd36);
        chk("t1_latency", 32'(rsp_at - t0), 32'd37);
        chk("t1_mosi_seq", 32'(mosi_seq[7:0]), 32'hA5);
        chk("t1_idle_mosi", 32'(mosi), 32'd0);

        // 2: clk_div=0 acts as H=1, full length, MISO low
        miso_mode = 0;
        start(16, 16'hFFFF, 16'd0);
        wait_rsp(200);
        chk("t2_data", 32'(rsp_d), 32'h0000);
        chk("t2_cs_low", 32'(cs_low_n - b_cs), 32'd34);
        chk("t2_latency", 32'(rsp_at - t0), 32'd35);
        chk("t2_rises", 32'(rises_n - b_rise), 32'd16);
        chk("t2_mosi_seq", 32'(mosi_seq), 32'hFFFF);

        // 3: len 4, MISO high, H=3
        miso_mode = 1;
        start(4, 16'h005A, 16'd3);
        wait_rsp(200);
        chk("t3_data", 32'(rsp_d), 32'h000F);
        chk("t3_mosi_seq", 32'(mosi_seq[3:0]), 32'hA);
        chk("t3_cs_low", 32'(cs_low_n - b_cs), 32'd30);
        chk("t3_latency", 32'(rsp_at - t0), 32'd31);

        // 4: illegal lengths 0 and 17
        start(0, 16'h1234, 16'd2);
        wait_rsp(20);
        chk("t4a_latency", 32'(rsp_at - t0), 32'd1);
        chk("t4a_err", 32'(rsp_e), 32'd1);
        chk("t4a_data", 32'(rsp_d), 32'd0);
        chk("t4a_cs", 32'(cs_low_n - b_cs), 32'd0);
        chk("t4a_sclk", 32'(rises_n - b_rise), 32'd0);
        start(17, 16'h1234, 16'd2);
        wait_rsp(20);
        chk("t4b_latency", 32'(rsp_at - t0), 32'd1);
        chk("t4b_err", 32'(rsp_e), 32'd1);
        chk("t4b_cs", 32'(cs_low_n - b_cs), 32'd0);
        chk("t4b_sclk", 32'(rises_n - b_rise), 32'd0);

        // 5: back-to-back with req_valid held and clk_div changed mid-transfer
        miso_mode = 2;
        @(negedge clk);
        bus.req_len   = 5'd8;
        bus.req_data  = 16'h003C;
        clk_div       = 16'd1;
        bus.req_valid = 1'b1;
        t0     = cyc;
        b_cs   = cs_low_n;
        b_rsp  = rsp_n;
        @(posedge clk);
        #1;
        clk_div      = 16'd3;
        bus.req_data = 16'h00C3;
        chk("t5_ready_busy", 32'(bus.req_ready), 32'd0);
        wait_rsp(200);
        chk("t5a_data", 32'(rsp_d), 32'h003C);
        chk("t5a_latency", 32'(rsp_at - t0), 32'd19);
        chk("t5a_cs_low", 32'(cs_low_n - b_cs), 32'd18);
        chk("t5_ready_idle", 32'(bus.req_ready), 32'd1);
        t1    = cyc;
        b_cs  = cs_low_n;
        b_rsp = rsp_n;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        chk("t5b_busy", 32'(busy), 32'd1);
        wait_rsp(400);
        chk("t5b_data", 32'(rsp_d), 32'h00C3);
        chk("t5b_latency", 32'(rsp_at - t1), 32'd55);
        chk("t5b_cs_low", 32'(cs_low_n - b_cs), 32'd54);
        chk("t5_gap", 32'(last_gap), 32'd2);

        // 6: reset during bit 5 of a len 8 transfer, then a clean transfer
        start(8, 16'h005A, 16'd2);
        while (cyc < t0 + 19) begin
            @(posedge clk);
            #1;
        end
        chk("t6_in_high", 32'(sclk), 32'd1);
        rst = 1'b0;
        #1;
        chk("t6_cs_n", 32'(cs_n), 32'd1);
        chk("t6_sclk", 32'(sclk), 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
        rst   = 1'b1;
        b_rsp = rsp_n;
        repeat (60) @(posedge clk);
        #1;
        chk("t6_no_rsp", 32'(rsp_n - b_rsp), 32'd0);
        start(8, 16'h0096, 16'd1);
        wait_rsp(200);
        chk("t6_data", 32'(rsp_d), 32'h0096);
        chk("t6_cs_low", 32'(cs_low_n - b_cs), 32'd18);
        chk("t6_err", 32'(rsp_e), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
